// File: rtl/trap_ctrl.sv
// Machine-mode trap/return controller: owns mstatus/mie/mip/mtvec/mepc/mcause and drives the next-PC select.
// Optional TRAP_VECTORED_EN macro enables vectored interrupt dispatch via mtvec[1:0]==01.
//
// state    | meaning
// BOOT     | post-reset hold, pc_src=RESET while the boot counter drains
// RUN      | normal execution, EX sampled for trap/mret/CSR write
// REDIRECT | one-cycle redirect (TRAP or EPC) with pipeline flush
module trap_ctrl #(
  parameter int unsigned RESET_CYCLES = 2,
  parameter logic [31:0] MTVEC_RESET  = 32'h0000_0100
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        valid_ex,
  input  logic [31:0] pc_ex,
  input  logic        illegal_ex,
  input  logic        ecall_ex,
  input  logic        mret_ex,
  input  logic        irq_ext,
  input  logic        irq_sw,
  input  logic        irq_tmr,
  input  logic        csr_we,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  output logic [1:0]  pc_src,
  output logic [31:0] pc_trap,
  output logic [31:0] mepc,
  output logic        flush
);

  typedef enum logic [1:0] {BOOT, RUN, REDIRECT} state_t;

  localparam logic [1:0]  PC_RESET = 2'b00;
  localparam logic [1:0]  PC_TRAP  = 2'b01;
  localparam logic [1:0]  PC_EPC   = 2'b10;
  localparam logic [1:0]  PC_NEXT  = 2'b11;

  localparam logic [11:0] A_MSTATUS = 12'h300;
  localparam logic [11:0] A_MIE     = 12'h304;
  localparam logic [11:0] A_MTVEC   = 12'h305;
  localparam logic [11:0] A_MEPC    = 12'h341;
  localparam logic [11:0] A_MCAUSE  = 12'h342;
  localparam logic [11:0] A_MIP     = 12'h344;

  localparam logic [31:0] IRQ_MASK    = 32'h0000_0888;
  localparam logic [3:0]  BOOT_CNT    = 4'(RESET_CYCLES);

  // Legalise an mtvec value: only direct (00) or vectored (01) mode survives.
  function automatic logic [31:0] tvec_legal(input logic [31:0] v);
`ifdef TRAP_VECTORED_EN
    return {v[31:2], 1'b0, (v[1:0] == 2'b01)};
`else
    return {v[31:2], 2'b00};
`endif
  endfunction

  state_t      state_q, state_d;
  logic [3:0]  cnt_q;
  logic        redir_epc_q;

  logic        mie_bit_q, mpie_q;
  logic        mie_bit_d, mpie_d;
  logic [31:0] mie_q, mie_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] pc_trap_d;

  logic [31:0] mip;
  logic [31:0] irq_act;
  logic        int_pend;
  logic        take;
  logic        mret_go;
  logic        csr_wr;
  logic [31:0] cause_take;
  logic        unused_pc_lsb;

  assign unused_pc_lsb = ^pc_ex[1:0];

  assign mip      = {20'b0, irq_ext, 3'b0, irq_tmr, 3'b0, irq_sw, 3'b0};
  assign irq_act  = mip & mie_q;
  assign int_pend = mie_bit_q & (|irq_act);

  assign take    = (state_q == RUN) & valid_ex & (illegal_ex | ecall_ex | int_pend);
  assign mret_go = (state_q == RUN) & valid_ex & mret_ex & ~take;
  assign csr_wr  = (state_q == RUN) & valid_ex & csr_we & ~take;

  always_comb begin
    cause_take = 32'h8000_0007;
    if (illegal_ex)      cause_take = 32'd2;
    else if (ecall_ex)   cause_take = 32'd11;
    else if (irq_act[11]) cause_take = 32'h8000_000B;
    else if (irq_act[3]) cause_take = 32'h8000_0003;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:     if (cnt_q <= 4'd1) state_d = RUN;
      RUN:      if (take || mret_go) state_d = REDIRECT;
      REDIRECT: state_d = RUN;
      default:  state_d = BOOT;
    endcase
  end

  always_comb begin
    mie_bit_d = mie_bit_q;
    mpie_d    = mpie_q;
    mie_d     = mie_q;
    mtvec_d   = mtvec_q;
    mepc_d    = mepc_q;
    mcause_d  = mcause_q;
    if (take) begin
      mepc_d    = {pc_ex[31:2], 2'b00};
      mcause_d  = cause_take;
      mpie_d    = mie_bit_q;
      mie_bit_d = 1'b0;
    end else begin
      if (csr_wr) begin
        case (csr_addr)
          A_MSTATUS: begin
            mie_bit_d = csr_wdata[3];
            mpie_d    = csr_wdata[7];
          end
          A_MIE:    mie_d    = csr_wdata & IRQ_MASK;
          A_MTVEC:  mtvec_d  = tvec_legal(csr_wdata);
          A_MEPC:   mepc_d   = {csr_wdata[31:2], 2'b00};
          A_MCAUSE: mcause_d = csr_wdata;
          default:  ;
        endcase
      end
      // mret restores the interrupt enable; it overrides a same-cycle mstatus write.
      if (mret_go) begin
        mie_bit_d = mpie_q;
        mpie_d    = 1'b1;
      end
    end
  end

  // Follow the cause being written this edge so a vectored target lines up with REDIRECT.
  always_comb begin
    pc_trap_d = {mtvec_q[31:2], 2'b00};
`ifdef TRAP_VECTORED_EN
    if (mtvec_q[1:0] == 2'b01 && mcause_d[31])
      pc_trap_d = {mtvec_q[31:2], 2'b00} + {26'b0, mcause_d[3:0], 2'b00};
`endif
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= BOOT;
      cnt_q       <= BOOT_CNT;
      redir_epc_q <= 1'b0;
      mie_bit_q   <= 1'b0;
      mpie_q      <= 1'b0;
      mie_q       <= '0;
      mtvec_q     <= tvec_legal(MTVEC_RESET);
      mepc_q      <= '0;
      mcause_q    <= '0;
      pc_trap     <= {MTVEC_RESET[31:2], 2'b00};
    end else begin
      state_q     <= state_d;
      if (state_q == BOOT && cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
      if (state_q == RUN) redir_epc_q <= mret_go;
      mie_bit_q   <= mie_bit_d;
      mpie_q      <= mpie_d;
      mie_q       <= mie_d;
      mtvec_q     <= mtvec_d;
      mepc_q      <= mepc_d;
      mcause_q    <= mcause_d;
      pc_trap     <= pc_trap_d;
    end
  end

  always_comb begin
    case (state_q)
      RUN:      pc_src = PC_NEXT;
      REDIRECT: pc_src = redir_epc_q ? PC_EPC : PC_TRAP;
      default:  pc_src = PC_RESET;
    endcase
  end

  assign flush = (state_q == REDIRECT);
  assign mepc  = mepc_q;

  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      A_MSTATUS: csr_rdata = {24'b0, mpie_q, 3'b0, mie_bit_q, 3'b0};
      A_MIE:     csr_rdata = mie_q;
      A_MTVEC:   csr_rdata = mtvec_q;
      A_MEPC:    csr_rdata = mepc_q;
      A_MCAUSE:  csr_rdata = mcause_q;
      A_MIP:     csr_rdata = mip;
      default:   csr_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: boot hold, traps, interrupts, mret, CSR access and reset mid-redirect.
module tb_trap_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        valid_ex, illegal_ex, ecall_ex, mret_ex;
  logic [31:0] pc_ex;
  logic        irq_ext, irq_sw, irq_tmr;
  logic        csr_we;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic [1:0]  pc_src;
  logic [31:0] pc_trap;
  logic [31:0] mepc;
  logic        flush;

  int n_cmp = 0;
  int n_bad = 0;

  trap_ctrl dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .valid_ex(valid_ex), .pc_ex(pc_ex),
    .illegal_ex(illegal_ex), .ecall_ex(ecall_ex), .mret_ex(mret_ex),
    .irq_ext(irq_ext), .irq_sw(irq_sw), .irq_tmr(irq_tmr),
    .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata), .pc_src(pc_src), .pc_trap(pc_trap),
    .mepc(mepc), .flush(flush)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clr_ex();
    valid_ex = 0; illegal_ex = 0; ecall_ex = 0; mret_ex = 0;
    csr_we = 0; csr_wdata = '0; pc_ex = '0;
  endtask

  task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
    csr_addr = a;
    #1;
    chk(tag, csr_rdata, exp);
  endtask

  task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
    valid_ex = 1; csr_we = 1; csr_addr = a; csr_wdata = d;
    step();
    clr_ex();
  endtask

  initial begin
    i_rst_n = 0;
    clr_ex();
    irq_ext = 0; irq_sw = 0; irq_tmr = 0; csr_addr = '0;
    step(); step();

    chk("rst_pc_src", 32'(pc_src), 32'd0);
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_pc_trap", pc_trap, 32'h100);
    chk("rst_mepc", mepc, 32'h0);
    rd("rst_mcause", 12'h342, 32'h0);
    rd("rst_mstatus", 12'h300, 32'h0);
    rd("rst_mie", 12'h304, 32'h0);
    rd("rst_mtvec", 12'h305, 32'h100);

    // boot hold: two cycles of RESET, EX activity ignored
    i_rst_n = 1;
    #1;
    chk("boot0_pc_src", 32'(pc_src), 32'd0);
    step();
    chk("boot1_pc_src", 32'(pc_src), 32'd0);
    chk("boot1_flush", 32'(flush), 32'd0);
    valid_ex = 1; ecall_ex = 1; pc_ex = 32'h10;
    step();
    clr_ex();
    chk("boot_done_pc_src", 32'(pc_src), 32'd3);
    chk("boot_done_flush", 32'(flush), 32'd0);

    // illegal instruction trap
    csr_write(12'h305, 32'h200);
    step();
    valid_ex = 1; illegal_ex = 1; pc_ex = 32'h40;
    step();
    clr_ex();
    chk("ill_pc_src", 32'(pc_src), 32'd1);
    chk("ill_pc_trap", pc_trap, 32'h200);
    chk("ill_flush", 32'(flush), 32'd1);
    chk("ill_mepc", mepc, 32'h40);
    rd("ill_mcause", 12'h342, 32'd2);
    rd("ill_mstatus", 12'h300, 32'h0);
    // instruction presented during REDIRECT is squashed
    valid_ex = 1; ecall_ex = 1; pc_ex = 32'h44;
    step();
    clr_ex();
    chk("ill_after_pc_src", 32'(pc_src), 32'd3);
    chk("ill_after_flush", 32'(flush), 32'd0);
    chk("redir_ignore_mepc", mepc, 32'h40);

    // external interrupt beats timer
    csr_write(12'h300, 32'h8);
    csr_write(12'h304, 32'hFFFF_FFFF);
    rd("mie_mask", 12'h304, 32'h888);
    irq_ext = 1; irq_tmr = 1;
    rd("mip_read", 12'h344, 32'h880);
    valid_ex = 1; pc_ex = 32'h80;
    step();
    clr_ex();
    chk("ext_pc_src", 32'(pc_src), 32'd1);
    chk("ext_mepc", mepc, 32'h80);
    rd("ext_mcause", 12'h342, 32'h8000_000B);
    rd("ext_mstatus", 12'h300, 32'h80);
    step();
    valid_ex = 1; mret_ex = 1; pc_ex = 32'h80;
    step();
    clr_ex();
    irq_ext = 0; irq_tmr = 0;
    chk("mret_pc_src", 32'(pc_src), 32'd2);
    chk("mret_flush", 32'(flush), 32'd1);
    chk("mret_mepc", mepc, 32'h80);
    rd("mret_mstatus", 12'h300, 32'h88);
    step();
    chk("mret_after_pc_src", 32'(pc_src), 32'd3);

    // software interrupt gated by MIE
    csr_write(12'h300, 32'h0);
    irq_sw = 1;
    valid_ex = 1; pc_ex = 32'h44;
    step();
    clr_ex();
    chk("sw_masked_pc_src", 32'(pc_src), 32'd3);
    csr_write(12'h300, 32'h8);
    chk("sw_wr_pc_src", 32'(pc_src), 32'd3);
    valid_ex = 1; pc_ex = 32'h48;
    step();
    clr_ex();
    irq_sw = 0;
    chk("sw_pc_src", 32'(pc_src), 32'd1);
    chk("sw_mepc", mepc, 32'h48);
    rd("sw_mcause", 12'h342, 32'h8000_0003);
    step();

    // ecall wins over a same-cycle CSR write
    valid_ex = 1; ecall_ex = 1; pc_ex = 32'h64;
    csr_we = 1; csr_addr = 12'h341; csr_wdata = 32'h123;
    step();
    clr_ex();
    chk("ecall_mepc", mepc, 32'h64);
    rd("ecall_mcause", 12'h342, 32'd11);
    chk("ecall_pc_src", 32'(pc_src), 32'd1);
    step();
    csr_write(12'h341, 32'h123);
    rd("mepc_wr", 12'h341, 32'h120);
    chk("mepc_port", mepc, 32'h120);
    csr_write(12'h7C0, 32'hFF);
    rd("unmapped", 12'h7C0, 32'h0);

    // mtvec mode bits and vectored dispatch
    csr_write(12'h305, 32'h201);
    step();
`ifdef TRAP_VECTORED_EN
    rd("mtvec_vec", 12'h305, 32'h201);
`else
    rd("mtvec_vec", 12'h305, 32'h200);
`endif
    csr_write(12'h300, 32'h8);
    irq_tmr = 1;
    valid_ex = 1; pc_ex = 32'h90;
    step();
    clr_ex();
    irq_tmr = 0;
    rd("tmr_mcause", 12'h342, 32'h8000_0007);
`ifdef TRAP_VECTORED_EN
    chk("tmr_pc_trap", pc_trap, 32'h21C);
`else
    chk("tmr_pc_trap", pc_trap, 32'h200);
`endif
    step();
    valid_ex = 1; ecall_ex = 1; pc_ex = 32'h94;
    step();
    clr_ex();
    chk("ecall_vec_pc_trap", pc_trap, 32'h200);
    chk("ecall_vec_pc_src", 32'(pc_src), 32'd1);

    // reset in the middle of REDIRECT
    i_rst_n = 0;
    #1;
    chk("midrst_pc_src", 32'(pc_src), 32'd0);
    chk("midrst_flush", 32'(flush), 32'd0);
    chk("midrst_mepc", mepc, 32'h0);
    chk("midrst_pc_trap", pc_trap, 32'h100);
    rd("midrst_mcause", 12'h342, 32'h0);
    step();
    i_rst_n = 1;
    step();
    chk("rerun_boot_pc_src", 32'(pc_src), 32'd0);
    chk("rerun_boot_flush", 32'(flush), 32'd0);
    step();
    chk("rerun_pc_src", 32'(pc_src), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Machine-mode trap/return controller for the 5-stage RISC-V core.
- Produces the PC-select code, trap target and saved exception PC consumed by the next-PC mux.
- Owns mstatus/mie/mip/mtvec/mepc/mcause.
- Samples exceptions, interrupts and mret at EX; issues a one-cycle registered redirect plus pipeline flush.

Parameters:
- RESET_CYCLES, 2, cycles pc_src is held at PC_RESET after reset deassertion (1..15).
- MTVEC_RESET, 32'h0000_0100, reset value of mtvec.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  reset; asynchronous, active-low.
- valid_ex  in  1  EX holds a real (non-bubble) instruction.
- pc_ex  in  32  PC of the EX instruction.
- illegal_ex  in  1  illegal-instruction exception at EX.
- ecall_ex  in  1  ecall at EX.
- mret_ex  in  1  mret at EX.
- irq_ext, irq_sw, irq_tmr  in  1 each  level interrupt lines, already synchronised.
- csr_we  in  1  CSR write strobe, qualified by valid_ex.
- csr_addr  in  12  CSR address for read and write.
- csr_wdata  in  32  CSR write data.
- csr_rdata  out  32  combinational CSR read data.
- pc_src  out  2  00 RESET, 01 TRAP, 10 EPC, 11 NEXT.
- pc_trap  out  32  trap target address.
- mepc  out  32  saved exception PC.
- flush  out  1  squash IF/ID/EX.

Behaviour:
- Reset values: pc_src=00, pc_trap=MTVEC_RESET, mepc=0, flush=0, mcause=0, mstatus.MIE=0, MPIE=0, mie=0, mtvec=MTVEC_RESET.
- FSM states: BOOT, RUN, REDIRECT.
- BOOT: counter loads RESET_CYCLES on reset; pc_src=00 until it reaches 0, then RUN with pc_src=11. EX inputs are ignored in BOOT.
- RUN, take condition: valid_ex & (illegal_ex | ecall_ex | int_pend), where int_pend = mstatus.MIE & |(mip & mie).
- Take priority: illegal (mcause 2) > ecall (11) > ext int (0x8000000B) > sw (0x80000003) > timer (0x80000007).
- On take, at the clock edge:
  - mepc <= {pc_ex[31:2],2'b00}; mcause set per priority above.
  - MPIE <= MIE; MIE <= 0.
  - Go to REDIRECT with pc_src=01 and flush=1 for exactly one cycle.
  - For interrupts the EX instruction is not committed and is re-executed on return.
- RUN, mret: if valid_ex & mret_ex and no take condition → MIE <= MPIE, MPIE <= 1; REDIRECT with pc_src=10 and flush=1 for one cycle. A trap in the same cycle wins over mret.
- REDIRECT: EX inputs and CSR writes are ignored because that instruction is squashed. Next state is RUN, pc_src=11, flush=0. Redirect latency is exactly 1 cycle after the EX sample.
- pc_trap: registered from mtvec base {mtvec[31:2],2'b00}, updated every cycle.
- CSR map:
  - 0x300 mstatus: bits 3 and 7 writable, all other bits read 0.
  - 0x304 mie: bits 3, 7, 11 writable.
  - 0x305 mtvec.
  - 0x341 mepc: bits [1:0] forced to 0.
  - 0x342 mcause.
  - 0x344 mip: read-only {irq_ext<<11, irq_tmr<<7, irq_sw<<3}.
  - Unmapped addresses read 0; writes to them are dropped.
- CSR writes take effect when csr_we & valid_ex in RUN with no take condition. A trap in the same cycle wins and the write is dropped. A write to mstatus.MIE affects interrupt take from the next cycle.
- Asynchronous reset at any point, including mid-REDIRECT, returns to BOOT with all reset values. No redirect is issued after reset.

Optional Feature:
- Macro: TRAP_VECTORED_EN.
- Defined: mtvec[1:0]==01 selects vectored mode; for interrupts pc_trap = base + 4*cause[3:0]; exceptions still use base. mtvec[1:0] is writable (values 00/01 only; 1x is stored as 00).
- Undefined: mtvec[1:0] reads 0 and ignores writes; pc_trap = base always.

Test Plan:
- Reset release with RESET_CYCLES=2 → pc_src=00 for 2 cycles, then 11; flush=0 throughout.
- mtvec=0x200, pc_ex=0x40, illegal_ex with valid_ex → next cycle pc_src=01, pc_trap=0x200, flush=1, mepc=0x40, mcause=2, MIE=0; following cycle pc_src=11.
- MIE=1, mie=0x888, irq_ext and irq_tmr both high, pc_ex=0x80 → mcause=0x8000000B, mepc=0x80, MPIE=1. Repeat with mret_ex → pc_src=10, mepc=0x80, MIE=1.
- MIE=0 with irq_sw high → no trap; CSR write mstatus=0x8 → trap on the next valid cycle with mcause=0x80000003.
- csr_we to mepc with 0x123 alongside ecall_ex → write dropped, mepc=pc_ex, mcause=11. Separate CSR write of mepc=0x123 reads back 0x120.
- TRAP_VECTORED_EN defined, mtvec=0x201, timer interrupt → pc_trap=0x21C. Ecall with the same mtvec → pc_trap=0x200.
